stream_demux_1to2: RTL

Registered 1-to-2 stream demultiplexer with valid/ready handshakes and packet-level route locking. It is the counterpart to the 2:1 select path: one producer stream is steered to one of two consumer streams, for example to split a single bus or peripheral data stream between two sinks. Each output owns a one-entry output register. The route is chosen on the first beat of a packet and held until the packet's last beat.

---
 rtl/stream_demux_1to2.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 valid/ready stream demultiplexer with packet-level route locking.
// Optional delivered-beat counters are built when STREAM_DEMUX_COUNT_EN is defined.
module stream_demux_1to2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic [15:0]      out0_count,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic [15:0]      out1_count
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             lock_sel_q, lock_sel_d;
    logic             route;
    logic             in_fire;
    logic             out0_fire, out1_fire;

    logic             out0_valid_q, out0_valid_d;
    logic [WIDTH-1:0] out0_data_q, out0_data_d;
    logic             out0_last_q, out0_last_d;
    logic             out1_valid_q, out1_valid_d;
    logic [WIDTH-1:0] out1_data_q, out1_data_d;
    logic             out1_last_q, out1_last_d;

    assign in_fire   = in_valid && in_ready;
    assign out0_fire = out0_valid_q && out0_ready;
    assign out1_fire = out1_valid_q && out1_ready;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lock_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        unique case (state_q)
            IDLE: begin
                if (in_fire && !in_last) begin
                    state_d    = LOCKED;
                    lock_sel_d = in_sel;
                end
            end
            LOCKED: begin
                if (in_fire && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The route follows in_sel only on a packet's first beat; ready looks at the routed output only.
    always_comb begin
        route    = (state_q == LOCKED) ? lock_sel_q : in_sel;
        in_ready = route ? (!out1_valid_q || out1_ready)
                         : (!out0_valid_q || out0_ready);
    end

    always_comb begin
        out0_valid_d = out0_valid_q;
        out0_data_d  = out0_data_q;
        out0_last_d  = out0_last_q;
        out1_valid_d = out1_valid_q;
        out1_data_d  = out1_data_q;
        out1_last_d  = out1_last_q;

        // A load wins over a drain, so a same-cycle load and drain keeps valid high.
        if (in_fire && !route) begin
            out0_valid_d = 1'b1;
            out0_data_d  = in_data;
            out0_last_d  = in_last;
        end else if (out0_fire) begin
            out0_valid_d = 1'b0;
        end

        if (in_fire && route) begin
            out1_valid_d = 1'b1;
            out1_data_d  = in_data;
            out1_last_d  = in_last;
        end else if (out1_fire) begin
            out1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_valid_q <= 1'b0;
            out0_data_q  <= '0;
            out0_last_q  <= 1'b0;
            out1_valid_q <= 1'b0;
            out1_data_q  <= '0;
            out1_last_q  <= 1'b0;
        end else begin
            out0_valid_q <= out0_valid_d;
            out0_data_q  <= out0_data_d;
            out0_last_q  <= out0_last_d;
            out1_valid_q <= out1_valid_d;
            out1_data_q  <= out1_data_d;
            out1_last_q  <= out1_last_d;
        end
    end

    assign out0_valid = out0_valid_q;
    assign out0_data  = out0_data_q;
    assign out0_last  = out0_last_q;
    assign out1_valid = out1_valid_q;
    assign out1_data  = out1_data_q;
    assign out1_last  = out1_last_q;

`ifdef STREAM_DEMUX_COUNT_EN
    logic [15:0] out0_count_q, out0_count_d;
    logic [15:0] out1_count_q, out1_count_d;

    // Counters saturate rather than wrap.
    always_comb begin
        out0_count_d = out0_count_q;
        out1_count_d = out1_count_q;
        if (out0_fire && (out0_count_q != 16'hFFFF)) out0_count_d = out0_count_q + 16'd1;
        if (out1_fire && (out1_count_q != 16'hFFFF)) out1_count_d = out1_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0_count_q <= 16'h0000;
            out1_count_q <= 16'h0000;
        end else begin
            out0_count_q <= out0_count_d;
            out1_count_q <= out1_count_d;
        end
    end

    assign out0_count = out0_count_q;
    assign out1_count = out1_count_q;
`else
    assign out0_count = 16'h0000;
    assign out1_count = 16'h0000;
`endif

endmodule
